// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction-fetch (I) and data (D) requesters.
// Grant -> mem_req 1 cycle, done 1 cycle after mem_ack/timeout; losers are held off. ARB_RR_EN selects round-robin.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_done,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                bus_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          owner
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [1:0]          owner_q, owner_d;
    logic                i_done_q, i_done_d;
    logic                d_done_q, d_done_d;
    logic                bus_err_q, bus_err_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                grant_d;
    logic                timeout;
`ifdef ARB_RR_EN
    logic                last_grant_q, last_grant_d;  // 1 = D, 0 = I
`endif

    always_comb begin
`ifdef ARB_RR_EN
        if (d_req && i_req) begin
            grant_d = ~last_grant_q;
        end else begin
            grant_d = d_req;
        end
`else
        grant_d = d_req;
`endif
    end

    assign timeout = (MAX_WAIT != 0) && (cnt_q == MAX_CNT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        owner_d     = owner_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        bus_err_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    mem_req_d = 1'b1;
`ifdef ARB_RR_EN
                    last_grant_d = grant_d;
`endif
                    if (grant_d) begin
                        state_d     = BUSY_D;
                        owner_d     = 2'b10;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wstrb_d = d_we ? d_wstrb : '0;
                    end else begin
                        state_d     = BUSY_I;
                        owner_d     = 2'b01;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                // A late ack in the timeout cycle still counts as a good completion.
                if (mem_ack || timeout) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    bus_err_d = ~mem_ack;
                    if (state_q == BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_ack ? mem_rdata : '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                owner_d = 2'b00;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            owner_q     <= 2'b00;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            owner_q     <= owner_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            bus_err_q   <= bus_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign owner     = owner_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign bus_err   = bus_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: completions are scoreboarded, bus-side behaviour checked inline.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, i_done, d_req, d_we, d_done, bus_err;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic [3:0]    d_wstrb, mem_wstrb;
    logic          mem_req, mem_we, mem_ack;
    logic [1:0]    owner;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_done(d_done), .d_rdata(d_rdata), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_d, input logic err, input logic [31:0] rd, input int c);
        exp_t e;
        e.is_d  = is_d;
        e.err   = err;
        e.rdata = rd;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    // Waits for the grant, checks the bus stays stable for waits+1 cycles, acks in the last one.
    task automatic serve(input int waits, input logic [31:0] rd, input logic exp_we,
                         input logic [31:0] exp_addr, input logic [1:0] exp_owner,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wdata, input string tag);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(64'(mem_req), 64'(1), {tag, "_mem_req"});
        for (int w = 0; w <= waits; w++) begin
            if (w > 0) step();
            chk(64'({mem_req, mem_we, owner, mem_wstrb}), 64'({1'b1, exp_we, exp_owner, exp_strb}), {tag, "_busy"});
            chk(64'(mem_addr), 64'(exp_addr), {tag, "_addr"});
            if (exp_we) chk(64'(mem_wdata), 64'(exp_wdata), {tag, "_wdata"});
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        chk(64'(mem_req), 64'(0), {tag, "_mem_req_drop"});
    endtask

    // Completion monitor: every done pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (i_done === 1'b1 || d_done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk(64'({i_done, d_done}), 64'(0), "unexpected_done");
                end else begin
                    e = sb.pop_front();
                    chk(64'({d_done, i_done}), 64'({e.is_d, ~e.is_d}), "done_port");
                    chk(64'(bus_err), 64'(e.err), "bus_err");
                    chk(64'(e.is_d ? d_rdata : i_rdata), 64'(e.rdata), "rdata");
                    chk(64'(cyc), 64'(e.cyc), "done_cycle");
                end
            end else if (bus_err === 1'b1) begin
                chk(64'(bus_err), 64'(0), "stray_bus_err");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_ack = 1'b0; mem_rdata = '0;
        step();
        step();
        chk(64'({mem_req, mem_we, owner, i_done, d_done, bus_err, mem_wstrb}), 64'(0), "reset_ctrl");
        chk(64'({i_rdata, d_rdata}), 64'(0), "reset_rdata");
        chk(64'(mem_addr), 64'(0), "reset_addr");
        rst_n = 1'b1;
        step();

        // Single fetch, zero-wait memory
        t0 = cyc;
        i_req = 1'b1; i_addr = 32'h0000_0040;
        push(1'b0, 1'b0, 32'h2408_0005, t0 + 2);
        serve(0, 32'h2408_0005, 1'b0, 32'h0000_0040, 2'b01, 4'h0, 32'h0, "t1");
        i_req = 1'b0;
        chk(64'(owner), 64'(2'b01), "t1_owner_resp");
        step();
        chk(64'(owner), 64'(2'b00), "t1_owner_idle");
        chk(64'(i_rdata), 64'(32'h2408_0005), "t1_rdata_held");

        // Simultaneous requests: D first, I after one idle cycle
        t0 = cyc;
        i_req = 1'b1; i_addr = 32'h0000_0080;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_wdata = $urandom; d_wstrb = 4'hF;
        push(1'b1, 1'b0, 32'h1111_2222, t0 + 2);
        push(1'b0, 1'b0, 32'h3333_4444, t0 + 5);
        serve(0, 32'h1111_2222, 1'b0, 32'h0000_3000, 2'b10, 4'h0, 32'h0, "t3d");
        d_req = 1'b0;
        serve(0, 32'h3333_4444, 1'b0, 32'h0000_0080, 2'b01, 4'h0, 32'h0, "t3i");
        i_req = 1'b0;
        step();

        // Write with three wait states; d_rdata keeps the earlier read value
        t0 = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        push(1'b1, 1'b0, 32'h1111_2222, t0 + 5);
        serve(3, $urandom, 1'b1, 32'h0000_1000, 2'b10, 4'hF, 32'hDEAD_BEEF, "t2");
        d_req = 1'b0; d_we = 1'b0;
        step();

        // Memory never answers: timeout after MAX_WAIT cycles
        t0 = cyc;
        d_req = 1'b1; d_addr = 32'h0000_2000;
        push(1'b1, 1'b1, 32'h0, t0 + 6);
        step();
        for (int c = 1; c <= 5; c++) begin
            chk(64'(mem_req), 64'(1), "t4_wait");
            step();
        end
        chk(64'(mem_req), 64'(0), "t4_mem_req_drop");
        d_req = 1'b0;
        step();
        chk(64'({owner, d_rdata}), 64'(0), "t4_after");

        // Ack lands in the timeout cycle: no error
        t0 = cyc;
        d_req = 1'b1; d_addr = 32'h0000_2004;
        push(1'b1, 1'b0, 32'hCAFE_F00D, t0 + 6);
        serve(4, 32'hCAFE_F00D, 1'b0, 32'h0000_2004, 2'b10, 4'h0, 32'h0, "t5");
        d_req = 1'b0;
        step();

        // Reset while BUSY_D: transaction is dropped silently
        d_req = 1'b1; d_addr = 32'h0000_2008;
        step();
        chk(64'({mem_req, owner}), 64'({1'b1, 2'b10}), "t6_busy");
        step();
        rst_n = 1'b0;
        step();
        chk(64'({mem_req, mem_we, owner, i_done, d_done, bus_err, mem_wstrb}), 64'(0), "t6_reset_ctrl");
        chk(64'({i_rdata, d_rdata}), 64'(0), "t6_reset_rdata");
        chk(64'(mem_addr), 64'(0), "t6_reset_addr");
        rst_n = 1'b1; d_req = 1'b0;
        step();
        t0 = cyc;
        i_req = 1'b1; i_addr = 32'h0000_0044;
        push(1'b0, 1'b0, 32'h55AA_55AA, t0 + 2);
        serve(0, 32'h55AA_55AA, 1'b0, 32'h0000_0044, 2'b01, 4'h0, 32'h0, "t6i");
        i_req = 1'b0;
        step();
        step();

        chk(64'(sb.size()), 64'(0), "sb_drained");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
